// File: rtl/cpu_mc_pkg.sv
// Shared types and constants for the cpu_mc multicycle core: FSM states, instruction field codes,
// memory command codes and register-number selectors.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StAddr, StMem, StWrite, StBranch, StHalt
  } state_e;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [2:0] OpcBranch = 3'b001;
  localparam logic [2:0] OpcCall   = 3'b010;
  localparam logic [2:0] OpcLdr    = 3'b011;
  localparam logic [2:0] OpcStr    = 3'b100;
  localparam logic [2:0] OpcAlu    = 3'b101;
  localparam logic [2:0] OpcMov    = 3'b110;

  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpCmp    = 2'b01;
  localparam logic [1:0] OpAnd    = 2'b10;
  localparam logic [1:0] OpMvn    = 2'b11;
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpMovImm = 2'b10;
  localparam logic [1:0] OpBx     = 2'b00;
  localparam logic [1:0] OpBl     = 2'b11;

  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShLsl  = 2'b01;
  localparam logic [1:0] ShLsr  = 2'b10;

  localparam logic [2:0] CondAl = 3'b000;
  localparam logic [2:0] CondEq = 3'b001;
  localparam logic [2:0] CondNe = 3'b010;
  localparam logic [2:0] CondLt = 3'b011;
  localparam logic [2:0] CondLe = 3'b100;

  localparam logic [1:0] NselRn = 2'd0;
  localparam logic [1:0] NselRd = 2'd1;
  localparam logic [1:0] NselRm = 2'd2;
  localparam logic [1:0] NselR7 = 2'd3;

  function automatic logic [2:0] nsel_to_reg(input logic [1:0] nsel, input logic [15:0] ir);
    case (nsel)
      NselRn:  return ir[10:8];
      NselRd:  return ir[7:5];
      NselRm:  return ir[2:0];
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic cond_taken(input logic [2:0] cond, input logic n, input logic v,
                                      input logic z);
    case (cond)
      CondAl:  return 1'b1;
      CondEq:  return z;
      CondNe:  return !z;
      CondLt:  return n ^ v;
      CondLe:  return (n ^ v) | z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Eight-entry register file: two combinational read ports, one synchronous write port and a
// synchronous active-low clear.
module cpu_mc_regfile #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              clr_ni,
  input  logic [2:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [2:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_mc.sv
// Multicycle 16-bit-encoding CPU core with a ready-handshaked shared memory port.
// Define CPU_CALL_EN to enable the BL/BX/BLX call instructions (opcode 010).
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, pc_br;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, mdr_q, mdr_d;
  logic              n_q, n_d, v_q, v_d, z_q, z_d;

  logic [2:0]        opcode, cond;
  logic [1:0]        op, sh, nsel, rb_nsel;
  logic [DATA_W-1:0] sximm8, sximm5, b_sh, diff, alu_res, addr_sum;
  logic [DATA_W-1:0] rdata_a, rdata_b, rf_wdata;
  logic              rf_we, instr_ok, cmp_v;

  assign opcode   = ir_q[15:13];
  assign op       = ir_q[12:11];
  assign cond     = ir_q[10:8];
  assign sh       = ir_q[4:3];
  assign sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign addr_sum = a_q + sximm5;
  assign pc_br    = pc_q + sximm8[ADDR_W-1:0];
  // Stores and calls need R[Rd] on the second read port.
  assign rb_nsel  = (opcode == OpcStr || opcode == OpcCall) ? NselRd : NselRm;

  cpu_mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk_i     (clk),
    .clr_ni    (reset),
    .raddr_a_i (nsel_to_reg(NselRn, ir_q)),
    .rdata_a_o (rdata_a),
    .raddr_b_i (nsel_to_reg(rb_nsel, ir_q)),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (nsel_to_reg(nsel, ir_q)),
    .wdata_i   (rf_wdata)
  );

  always_comb begin
    case (sh)
      ShNone:  b_sh = b_q;
      ShLsl:   b_sh = {b_q[DATA_W-2:0], 1'b0};
      ShLsr:   b_sh = {1'b0, b_q[DATA_W-1:1]};
      default: b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
    endcase
    diff  = a_q - b_sh;
    cmp_v = (a_q[DATA_W-1] != b_sh[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
    if (opcode == OpcMov) begin
      alu_res = b_sh;
    end else begin
      case (op)
        OpAdd:   alu_res = a_q + b_sh;
        OpAnd:   alu_res = a_q & b_sh;
        OpMvn:   alu_res = ~b_sh;
        default: alu_res = diff;
      endcase
    end
  end

  always_comb begin
    case (opcode)
      OpcMov:                    instr_ok = (op == OpMovImm) || (op == OpMovReg);
      OpcAlu:                    instr_ok = 1'b1;
      OpcLdr, OpcStr, OpcBranch: instr_ok = (op == 2'b00);
`ifdef CPU_CALL_EN
      OpcCall:                   instr_ok = (op != 2'b01);
`endif
      default:                   instr_ok = 1'b0;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    nsel     = NselRd;
    rf_wdata = c_q;
    if (state_q == StWrite) begin
      rf_we = 1'b1;
      if (opcode == OpcMov && op == OpMovImm) begin
        nsel     = NselRn;
        rf_wdata = sximm8;
      end else if (opcode == OpcLdr) begin
        rf_wdata = mdr_q;
      end
    end
`ifdef CPU_CALL_EN
    if (state_q == StBranch && opcode == OpcCall && op != OpBx) begin
      rf_we    = 1'b1;
      nsel     = NselR7;
      rf_wdata = DATA_W'(pc_q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_d    = mem_rdata[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = rdata_a;
        b_d = rdata_b;
        if (!instr_ok)                              state_d = StHalt;
        else if (opcode == OpcMov && op == OpMovImm) state_d = StWrite;
        else if (opcode == OpcMov || opcode == OpcAlu) state_d = StExec;
        else if (opcode == OpcLdr || opcode == OpcStr) state_d = StAddr;
        else                                        state_d = StBranch;
      end
      StExec: begin
        if (opcode == OpcAlu && op == OpCmp) begin
          n_d     = diff[DATA_W-1];
          z_d     = (diff == '0);
          v_d     = cmp_v;
          state_d = StFetch;
        end else begin
          c_d     = alu_res;
          state_d = StWrite;
        end
      end
      StAddr: begin
        c_d     = addr_sum;
        addr_d  = addr_sum[ADDR_W-1:0];
        state_d = StMem;
      end
      StMem: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = (opcode == OpcLdr) ? StWrite : StFetch;
        end
      end
      StWrite: state_d = StFetch;
      StBranch: begin
        state_d = StFetch;
        if (opcode == OpcBranch) begin
          if (cond_taken(cond, n_q, v_q, z_q)) pc_d = pc_br;
        end
`ifdef CPU_CALL_EN
        else if (opcode == OpcCall) begin
          pc_d = (op == OpBl) ? pc_br : b_q[ADDR_W-1:0];
        end
`endif
      end
      StHalt: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  // Asserting reset drops the command immediately so an in-flight store never lands.
  always_comb begin
    mem_cmd  = MNONE;
    mem_addr = pc_q;
    if (state_q == StMem) begin
      mem_addr = addr_q;
      if (reset) mem_cmd = (opcode == OpcStr) ? MWRITE : MREAD;
    end else if (state_q == StFetch && reset) begin
      mem_cmd = MREAD;
    end
  end

  assign mem_wdata = b_q;
  assign out       = c_q;
  assign N         = n_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign halted    = (state_q == StHalt);
  assign pc_dbg    = pc_q;

endmodule
